// File: rtl/dtc_be_pkg.sv
// Shared constants, lane state encoding and the window tap helper for the DTC back-end deframer.
package dtc_be_pkg;

  localparam int WORD_W    = 32;
  localparam int SLIP_W    = 5;
  localparam int FRAME_W   = 84;
  localparam int LANE0_LSB = 0;
  localparam int LANE1_LSB = 40;

  localparam logic [WORD_W-1:0] DEF_HEADER = 32'hF0F0_0A0A;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lane_state_e;

  // Word starting s bits below the MSB of the 64-bit {prev, cur} window.
  function automatic logic [WORD_W-1:0] window_word(input logic [2*WORD_W-1:0] win,
                                                    input logic [SLIP_W-1:0]   s);
    return WORD_W'(win >> (WORD_W - int'(s)));
  endfunction

endpackage

// File: rtl/dtc_pkt_aligner.sv
// One CIC lane: bit-alignment search against the packet header, lock tracking and
// registered packet output with SOP/EOP markers.
module dtc_pkt_aligner
  import dtc_be_pkg::*;
#(
  parameter logic [WORD_W-1:0] HEADER     = DEF_HEADER,
  parameter int                PKT_WORDS  = 8,
  parameter int                LOCK_CNT   = 3,
  parameter int                UNLOCK_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word,
  input  logic              word_valid,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  output logic              sop,
  output logic              eop,
  output logic              locked,
  output logic [SLIP_W-1:0] slip,
  output logic [15:0]       err_cnt
);

  localparam int IDX_W  = $clog2(PKT_WORDS);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_WORDS - 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_TGT = MISS_W'(UNLOCK_CNT);

  lane_state_e        state;
  logic [WORD_W-1:0]  prev_word;
  logic [IDX_W-1:0]   word_idx;
  logic [IDX_W-1:0]   next_idx;
  logic [GOOD_W-1:0]  good;
  logic [GOOD_W-1:0]  good_nxt;
  logic [MISS_W-1:0]  miss;
  logic [MISS_W-1:0]  miss_nxt;
  logic [2*WORD_W-1:0] win;
  logic [WORD_W-1:0]  aligned;
  logic               hdr_ok;
  logic               hit;
  logic [SLIP_W-1:0]  hit_slip;

  assign win      = {prev_word, word};
  assign aligned  = window_word(win, slip);
  assign hdr_ok   = (aligned == HEADER);
  assign next_idx = (word_idx == LAST_IDX) ? '0 : word_idx + IDX_W'(1);
  assign good_nxt = good + GOOD_W'(1);
  assign miss_nxt = miss + MISS_W'(1);

  // Scan from the top offset down so the lowest matching offset is the one kept.
  always_comb begin
    hit      = 1'b0;
    hit_slip = '0;
    for (int s = WORD_W - 1; s >= 0; s--) begin
      if (window_word(win, SLIP_W'(s)) == HEADER) begin
        hit      = 1'b1;
        hit_slip = SLIP_W'(s);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      prev_word <= '0;
      word_idx  <= '0;
      good      <= '0;
      miss      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      locked    <= 1'b0;
      slip      <= '0;
      err_cnt   <= '0;
    end else begin
      valid <= 1'b0;
      sop   <= 1'b0;
      eop   <= 1'b0;
      // Lock flag drops one cycle after the final emitted word of a lost stream.
      if (state == SEARCH) locked <= 1'b0;

      if (word_valid) begin
        prev_word <= word;
        word_idx  <= next_idx;
        case (state)
          SEARCH: begin
            word_idx <= '0;
            if (hit) begin
              slip     <= hit_slip;
              word_idx <= IDX_W'(1);
              good     <= GOOD_W'(1);
              miss     <= '0;
              state    <= VERIFY;
            end
          end

          VERIFY: begin
            if (word_idx == '0) begin
              if (hdr_ok) begin
                good <= good_nxt;
                // The header that completes verification opens the locked stream.
                if (good_nxt == GOOD_TGT) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                  valid  <= 1'b1;
                  sop    <= 1'b1;
                  eop    <= (word_idx == LAST_IDX);
                  data   <= aligned;
                end
              end else begin
                good  <= '0;
                state <= SEARCH;
              end
            end
          end

          LOCKED: begin
            valid <= 1'b1;
            data  <= aligned;
            sop   <= (word_idx == '0);
            eop   <= (word_idx == LAST_IDX);
            if (word_idx == '0) begin
              if (hdr_ok) begin
                miss <= '0;
              end else if (miss_nxt == MISS_TGT) begin
                miss  <= '0;
                good  <= '0;
                state <= SEARCH;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              end else begin
                miss <= miss_nxt;
              end
            end
          end

          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: rtl/dtc_be_deframer.sv
// DTC back-end deframer: slices the two CIC lanes out of each 84-bit frame and aligns each
// lane independently.
module dtc_be_deframer
  import dtc_be_pkg::*;
#(
  parameter logic [WORD_W-1:0] HEADER     = DEF_HEADER,
  parameter int                PKT_WORDS  = 8,
  parameter int                LOCK_CNT   = 3,
  parameter int                UNLOCK_CNT = 2
) (
  input  logic               CLK40,
  input  logic               RST,
  input  logic [FRAME_W-1:0] FRAME_IN,
  input  logic               FRAME_VALID,
  output logic [WORD_W-1:0]  CIC0_DATA,
  output logic               CIC0_VALID,
  output logic               CIC0_SOP,
  output logic               CIC0_EOP,
  output logic               CIC0_LOCKED,
  output logic [SLIP_W-1:0]  CIC0_SLIP,
  output logic [15:0]        CIC0_ERR_CNT,
  output logic [WORD_W-1:0]  CIC1_DATA,
  output logic               CIC1_VALID,
  output logic               CIC1_SOP,
  output logic               CIC1_EOP,
  output logic               CIC1_LOCKED,
  output logic [SLIP_W-1:0]  CIC1_SLIP,
  output logic [15:0]        CIC1_ERR_CNT
);

  // Gap byte and top nibbles of the frame carry nothing for the CIC lanes.
  logic unused_frame_bits;
  assign unused_frame_bits = ^{FRAME_IN[FRAME_W-1:LANE1_LSB+WORD_W],
                               FRAME_IN[LANE1_LSB-1:LANE0_LSB+WORD_W]};

  dtc_pkt_aligner #(
    .HEADER(HEADER), .PKT_WORDS(PKT_WORDS), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
  ) u_lane0 (
    .clk        (CLK40),
    .rst        (RST),
    .word       (FRAME_IN[LANE0_LSB +: WORD_W]),
    .word_valid (FRAME_VALID),
    .data       (CIC0_DATA),
    .valid      (CIC0_VALID),
    .sop        (CIC0_SOP),
    .eop        (CIC0_EOP),
    .locked     (CIC0_LOCKED),
    .slip       (CIC0_SLIP),
    .err_cnt    (CIC0_ERR_CNT)
  );

  dtc_pkt_aligner #(
    .HEADER(HEADER), .PKT_WORDS(PKT_WORDS), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
  ) u_lane1 (
    .clk        (CLK40),
    .rst        (RST),
    .word       (FRAME_IN[LANE1_LSB +: WORD_W]),
    .word_valid (FRAME_VALID),
    .data       (CIC1_DATA),
    .valid      (CIC1_VALID),
    .sop        (CIC1_SOP),
    .eop        (CIC1_EOP),
    .locked     (CIC1_LOCKED),
    .slip       (CIC1_SLIP),
    .err_cnt    (CIC1_ERR_CNT)
  );

endmodule

// File: tb/tb_dtc_be_deframer.sv
// Directed bench for dtc_be_deframer: lock acquisition, bit slip, header loss, gaps, reset and
// lane independence.
module tb_dtc_be_deframer;

  localparam logic [31:0] HDR = 32'hF0F0_0A0A;

  logic        clk40 = 1'b0;
  logic        rst;
  logic [83:0] frame_in;
  logic        frame_valid;

  logic [31:0] cic0_data, cic1_data;
  logic        cic0_valid, cic0_sop, cic0_eop, cic0_locked;
  logic        cic1_valid, cic1_sop, cic1_eop, cic1_locked;
  logic [4:0]  cic0_slip, cic1_slip;
  logic [15:0] cic0_err_cnt, cic1_err_cnt;

  typedef struct packed {
    logic [31:0] d;
    logic        v;
    logic        s;
    logic        e;
    logic        l;
    logic [4:0]  sl;
    logic [15:0] er;
  } out_t;

  out_t o [2];
  assign o[0] = {cic0_data, cic0_valid, cic0_sop, cic0_eop, cic0_locked, cic0_slip, cic0_err_cnt};
  assign o[1] = {cic1_data, cic1_valid, cic1_sop, cic1_eop, cic1_locked, cic1_slip, cic1_err_cnt};

  int          checks = 0;
  int          passed = 0;
  int          k;
  int          rot0, rot1;
  logic [31:0] last0, last1;

  always #5 clk40 = ~clk40;

  dtc_be_deframer dut (
    .CLK40        (clk40),
    .RST          (rst),
    .FRAME_IN     (frame_in),
    .FRAME_VALID  (frame_valid),
    .CIC0_DATA    (cic0_data),
    .CIC0_VALID   (cic0_valid),
    .CIC0_SOP     (cic0_sop),
    .CIC0_EOP     (cic0_eop),
    .CIC0_LOCKED  (cic0_locked),
    .CIC0_SLIP    (cic0_slip),
    .CIC0_ERR_CNT (cic0_err_cnt),
    .CIC1_DATA    (cic1_data),
    .CIC1_VALID   (cic1_valid),
    .CIC1_SOP     (cic1_sop),
    .CIC1_EOP     (cic1_eop),
    .CIC1_LOCKED  (cic1_locked),
    .CIC1_SLIP    (cic1_slip),
    .CIC1_ERR_CNT (cic1_err_cnt)
  );

  // Packet word idx of the reference stream: header every 8 words, sparse payload otherwise.
  function automatic logic [31:0] orig(input int idx);
    if (idx % 8 == 0) return HDR;
    return (32'((idx / 8) & 7) << 8) | 32'(idx % 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic exp_lane(input int ln, input string tag, input logic v, input logic sp,
                          input logic ep, input logic lk, input logic [31:0] d,
                          input logic [4:0] sl, input logic [15:0] er);
    string p;
    p = $sformatf("%s_l%0d", tag, ln);
    chk({p, "_valid"},  32'(o[ln].v),  32'(v));
    chk({p, "_sop"},    32'(o[ln].s),  32'(sp));
    chk({p, "_eop"},    32'(o[ln].e),  32'(ep));
    chk({p, "_locked"}, 32'(o[ln].l),  32'(lk));
    chk({p, "_slip"},   32'(o[ln].sl), 32'(sl));
    chk({p, "_err"},    32'(o[ln].er), 32'(er));
    if (v) chk({p, "_data"}, o[ln].d, d);
  endtask

  // Drives one frame; each lane carries its reference stream delayed by rot bits.
  task automatic drive(input logic [31:0] o0, input logic [31:0] o1, input logic v);
    logic [63:0] t0, t1;
    t0 = {last0, o0};
    t1 = {last1, o1};
    @(negedge clk40);
    frame_in    = {12'hABC, t1[31+rot1 -: 32], 8'h5A, t0[31+rot0 -: 32]};
    frame_valid = v;
    if (v) begin
      last0 = o0;
      last1 = o1;
    end
    @(posedge clk40);
    #1;
  endtask

  // Push reference word k; the aligner then shows the previous reference word.
  task automatic push_chk(input bit corrupt, input bit lk, input logic [4:0] sl,
                          input logic [15:0] er, input bit garbage1);
    logic [31:0] o0, o1, ed;
    int pos;
    string tag;
    o0  = corrupt ? 32'h0 : orig(k);
    o1  = garbage1 ? ((k % 2) ? 32'h2492_4924 : 32'h9249_2492) : o0;
    ed  = last0;
    pos = (k - 1) % 8;
    tag = $sformatf("k%0d", k);
    drive(o0, o1, 1'b1);
    k++;
    exp_lane(0, tag, lk, lk && pos == 0, lk && pos == 7, lk, ed, sl, er);
    if (garbage1) begin
      chk({tag, "_l1_valid"},  32'(cic1_valid),  32'd0);
      chk({tag, "_l1_locked"}, 32'(cic1_locked), 32'd0);
      chk({tag, "_l1_err"},    32'(cic1_err_cnt), 32'd0);
    end else begin
      exp_lane(1, tag, lk, lk && pos == 0, lk && pos == 7, lk, ed, sl, er);
    end
  endtask

  task automatic gap(input logic [15:0] er);
    drive(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    exp_lane(0, $sformatf("gap%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 5'd0, er);
    exp_lane(1, $sformatf("gap%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 5'd0, er);
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk40);
    rst         = 1'b1;
    frame_valid = 1'b1;
    frame_in    = {12'h0, HDR, 8'h0, HDR};
    @(posedge clk40);
    #1;
    for (int ln = 0; ln < 2; ln++) begin
      exp_lane(ln, tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 16'd0);
      chk($sformatf("%s_l%0d_data", tag, ln), o[ln].d, 32'h0);
    end
    @(negedge clk40);
    rst         = 1'b0;
    frame_valid = 1'b0;
    k     = 0;
    last0 = '0;
    last1 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; frame_valid = 1'b0; frame_in = '0;
    rot0 = 0; rot1 = 0; k = 0; last0 = '0; last1 = '0;

    rst_pulse("por");

    // Slip 0, back-to-back packets: lock on the third header, then steady SOP/EOP.
    for (int i = 0; i <= 40; i++) push_chk(1'b0, i >= 17, 5'd0, 16'd0, 1'b0);

    // Single corrupted header is tolerated; two in a row drop lock, then re-lock.
    for (int i = 41; i <= 104; i++)
      push_chk(i == 48 || i == 64 || i == 72, i <= 73 || i >= 97, 5'd0,
               (i >= 73) ? 16'd1 : 16'd0, 1'b0);

    // Alternating gaps: nothing emitted on gaps, stream continues on valid frames.
    for (int i = 0; i < 16; i++) begin
      gap(16'd1);
      push_chk(1'b0, 1'b1, 5'd0, 16'd1, 1'b0);
    end

    // Reset mid-packet while locked clears everything, then re-lock from scratch.
    push_chk(1'b0, 1'b1, 5'd0, 16'd1, 1'b0);
    push_chk(1'b0, 1'b1, 5'd0, 16'd1, 1'b0);
    rst_pulse("rst_mid");
    for (int i = 0; i <= 25; i++) push_chk(1'b0, i >= 17, 5'd0, 16'd0, 1'b0);

    // Stream rotated by 13 bits on both lanes.
    rst_pulse("rst_rot13");
    rot0 = 13; rot1 = 13;
    for (int i = 0; i <= 33; i++)
      push_chk(1'b0, i >= 17, (i >= 1) ? 5'd13 : 5'd0, 16'd0, 1'b0);

    // Lane 0 at slip 5, lane 1 carries headerless garbage.
    rst_pulse("rst_indep");
    rot0 = 5; rot1 = 0;
    for (int i = 0; i <= 33; i++)
      push_chk(1'b0, i >= 17, (i >= 1) ? 5'd5 : 5'd0, 16'd0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
